// File: rtl/wave_capture_if.sv
// Sample-stream and RAM-write bundle for wave_capture_ctrl.
// slave: the capture controller; master: the codec/RAM side driving it.
//
// Signals:
//   new_sample_ready  strobe, new_sample_in valid
//   new_sample_in     signed 16-bit audio sample
//   vsync             display vertical sync level
//   write_address     RAM write address {half, index}
//   write_enable      RAM write strobe, one cycle per sample
//   write_sample      offset-binary 8-bit sample
//   read_index        RAM half owned by the display
//   capture_state     00 ARMED, 01 ACTIVE, 10 WAIT
interface wave_capture_if;
   logic        new_sample_ready;
   logic [15:0] new_sample_in;
   logic        vsync;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;
   logic [1:0]  capture_state;

   modport master (
      output new_sample_ready,
      output new_sample_in,
      output vsync,
      input  write_address,
      input  write_enable,
      input  write_sample,
      input  read_index,
      input  capture_state
   );

   modport slave (
      input  new_sample_ready,
      input  new_sample_in,
      input  vsync,
      output write_address,
      output write_enable,
      output write_sample,
      output read_index,
      output capture_state
   );
endinterface

// File: rtl/wave_capture_ctrl.sv
// Waveform capture sequencer: fills the RAM half the display is not
// reading with 256 samples per trigger, then flips halves on vsync.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    wave_capture_if.slave (sample strobe/data, vsync in;
//          RAM write address/enable/data, read_index, state out)
// Parameters:
//   ARM_TIMEOUT  strobes in ARMED before a forced trigger (0 = never)
//   DECIM        decimation factor, only with WAVE_CAPTURE_DECIMATE_EN
// Build option:
//   WAVE_CAPTURE_DECIMATE_EN  accept every DECIM-th strobe in ACTIVE
module wave_capture_ctrl #(
   parameter int ARM_TIMEOUT = 1024,
   parameter int DECIM       = 2
) (
   input logic         clk,
   input logic         reset,
   wave_capture_if.slave bus
);

   localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_ARMED  = 2'b00,
      S_ACTIVE = 2'b01,
      S_WAIT   = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic          rd_idx_q, rd_idx_d;
   logic          we_q, we_d;
   logic [8:0]    addr_q, addr_d;
   logic [7:0]    smp_q, smp_d;
   logic [7:0]    cnt_q, cnt_d;
   // Only the sign of the previous sample matters for crossing detection.
   logic          prev_neg_q, prev_neg_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          vsync_q;

   logic          strobe;
   logic          crossing;
   logic          vsync_rise;
   logic [TW-1:0] tmo_inc;
   logic          force_trig;
   logic [7:0]    conv;
   logic          accept;

`ifdef WAVE_CAPTURE_DECIMATE_EN
   localparam int SW = (DECIM > 1) ? $clog2(DECIM) : 1;
   logic [SW-1:0] skip_q, skip_d;
`endif

   assign strobe     = bus.new_sample_ready;
   assign crossing   = strobe && prev_neg_q && !bus.new_sample_in[15];
   assign vsync_rise = bus.vsync && !vsync_q;
   assign tmo_inc    = tmo_q + 1'b1;
   assign force_trig = (ARM_TIMEOUT != 0) && (tmo_inc == TW'(ARM_TIMEOUT));
   // Signed to offset-binary: flip the MSB of the top byte.
   assign conv       = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};

`ifdef WAVE_CAPTURE_DECIMATE_EN
   // skip_q counts strobes since the last accepted one.
   assign accept = strobe && (skip_q == SW'(DECIM - 1));
`else
   assign accept = strobe;
`endif

   always_comb begin
      state_d    = state_q;
      rd_idx_d   = rd_idx_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      smp_d      = smp_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      prev_neg_d = strobe ? bus.new_sample_in[15] : prev_neg_q;
`ifdef WAVE_CAPTURE_DECIMATE_EN
      skip_d     = skip_q;
`endif

      unique case (state_q)
         S_ARMED: begin
            if (strobe) begin
               if (crossing || force_trig) begin
                  we_d    = 1'b1;
                  addr_d  = {~rd_idx_q, 8'h00};
                  smp_d   = conv;
                  cnt_d   = 8'd1;
                  tmo_d   = '0;
                  state_d = S_ACTIVE;
`ifdef WAVE_CAPTURE_DECIMATE_EN
                  skip_d  = '0;
`endif
               end else begin
                  tmo_d = tmo_inc;
               end
            end
         end
         S_ACTIVE: begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
            if (strobe) begin
               skip_d = accept ? '0 : skip_q + 1'b1;
            end
`endif
            if (accept) begin
               we_d   = 1'b1;
               addr_d = {~rd_idx_q, cnt_q};
               smp_d  = conv;
               cnt_d  = cnt_q + 8'd1;
               // Last slot written; the 8-bit count wraps to 0.
               if (cnt_q == 8'hFF) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (vsync_rise) begin
               rd_idx_d = ~rd_idx_q;
               state_d  = S_ARMED;
            end
         end
         default: begin
            state_d = S_ARMED;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_ARMED;
         rd_idx_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         smp_q      <= '0;
         cnt_q      <= '0;
         prev_neg_q <= 1'b0;
         tmo_q      <= '0;
         vsync_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_idx_q   <= rd_idx_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         smp_q      <= smp_d;
         cnt_q      <= cnt_d;
         prev_neg_q <= prev_neg_d;
         tmo_q      <= tmo_d;
         vsync_q    <= bus.vsync;
      end
   end

`ifdef WAVE_CAPTURE_DECIMATE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         skip_q <= '0;
      end else begin
         skip_q <= skip_d;
      end
   end
`endif

   assign bus.write_address = addr_q;
   assign bus.write_enable  = we_q;
   assign bus.write_sample  = smp_q;
   assign bus.read_index    = rd_idx_q;
   assign bus.capture_state = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Self-checking bench for wave_capture_ctrl: directed scenarios plus
// random stimulus against a per-strobe behavioural capture model.
module tb_wave_capture_ctrl;

   localparam int ARM_TIMEOUT = 1024;
   localparam int DECIM       = 2;
`ifdef WAVE_CAPTURE_DECIMATE_EN
   localparam int D = DECIM;
`else
   localparam int D = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wave_capture_if bus ();

   wave_capture_ctrl #(
      .ARM_TIMEOUT(ARM_TIMEOUT),
      .DECIM      (DECIM)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;

   // Behavioural model: mode 0 armed, 1 capturing, 2 waiting for vsync.
   int m_mode, m_idle, m_written, m_k, m_prev;
   bit m_page, m_vs;
   int exp_we, exp_addr, exp_smp;

   task automatic chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_write(int idx, int sv);
      exp_we   = 1;
      exp_addr = (m_page ? 0 : 256) + idx;
      exp_smp  = (sv >>> 8) + 128;
   endtask

   task automatic model_step(bit r, int sv, bit v, bit rst);
      bit rise;
      if (rst) begin
         m_mode = 0; m_page = 0; m_prev = 0; m_idle = 0;
         m_written = 0; m_k = 0; m_vs = 0;
         exp_we = 0; exp_addr = 0; exp_smp = 0;
         return;
      end
      exp_we = 0;
      rise = v && !m_vs;
      m_vs = v;
      case (m_mode)
         0: if (r) begin
            m_idle++;
            if ((m_prev < 0 && sv >= 0) ||
                (ARM_TIMEOUT != 0 && m_idle == ARM_TIMEOUT)) begin
               m_write(0, sv);
               m_written = 1; m_k = 0; m_idle = 0; m_mode = 1;
            end
         end
         1: if (r) begin
            m_k++;
            if (m_k % D == 0) begin
               m_write(m_written, sv);
               m_written++;
               if (m_written == 256) begin
                  m_written = 0;
                  m_mode = 2;
               end
            end
         end
         default: if (rise) begin
            m_page = !m_page;
            m_mode = 0;
         end
      endcase
      if (r) m_prev = sv;
   endtask

   // Drive one cycle, predict it, then compare just after the edge.
   task automatic cyc(bit r, int sv, bit v, bit rst);
      bus.new_sample_ready = r;
      bus.new_sample_in    = 16'(sv);
      bus.vsync            = v;
      reset                = rst;
      model_step(r, sv, v, rst);
      @(posedge clk);
      #1;
      chk("write_enable", int'(bus.write_enable), exp_we);
      chk("capture_state", int'(bus.capture_state), m_mode);
      chk("read_index", int'(bus.read_index), int'(m_page));
      if (exp_we != 0) begin
         chk("write_address", int'(bus.write_address), exp_addr);
         chk("write_sample", int'(bus.write_sample), exp_smp);
      end
      if (bus.write_enable) wr_cnt++;
   endtask

   initial begin
      int n;
      bit vs;
      bus.new_sample_ready = 1'b0;
      bus.new_sample_in    = '0;
      bus.vsync            = 1'b0;
      reset                = 1'b1;

      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("rst_we", int'(bus.write_enable), 0);
      chk("rst_addr", int'(bus.write_address), 0);
      chk("rst_sample", int'(bus.write_sample), 0);
      chk("rst_state", int'(bus.capture_state), 0);
      chk("rst_read_index", int'(bus.read_index), 0);

      // First strobe after reset cannot trigger; the crossing does.
      cyc(1, -100, 0, 0);
      chk("no_first_trig", int'(bus.write_enable), 0);
      wr_cnt = 0;
      cyc(1, 50, 0, 0);
      chk("trig_we", int'(bus.write_enable), 1);
      chk("trig_addr", int'(bus.write_address), 'h100);
      chk("trig_sample", int'(bus.write_sample), 'h80);
      chk("trig_state", int'(bus.capture_state), 1);

      // Fill the remainder of the buffer with a ramp.
      for (int i = 1; i < 256 * D; i++) begin
         cyc(1, (i * 53) % 30000 - 15000, 0, 0);
         if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0);
      end
      chk("ramp_writes", wr_cnt, 256);
      chk("ramp_state", int'(bus.capture_state), 2);
      chk("ramp_read_index", int'(bus.read_index), 0);
      cyc(1, 1000, 0, 0);
      chk("extra_no_write", int'(bus.write_enable), 0);
      chk("extra_state", int'(bus.capture_state), 2);

      // vsync rise in WAIT flips the display half.
      cyc(0, 0, 1, 0);
      chk("flip_read_index", int'(bus.read_index), 1);
      chk("flip_state", int'(bus.capture_state), 0);
      cyc(0, 0, 0, 0);

      // Constant positive input forces a trigger on strobe 1024.
      n = 0;
      for (int i = 0; i < 1100; i++) begin
         cyc(1, 1000, 0, 0);
         n++;
         if (bus.write_enable) break;
      end
      chk("timeout_strobes", n, 1024);
      chk("timeout_addr", int'(bus.write_address), 'h000);
      chk("timeout_sample", int'(bus.write_sample), 'h83);

      // Reset after 100 writes abandons the capture.
      wr_cnt = 1;
      for (int i = 0; i < 400 * D && wr_cnt < 100; i++) begin
         cyc(1, i * 7, 0, 0);
      end
      chk("pre_reset_writes", wr_cnt, 100);
      cyc(1, 5, 0, 1);
      chk("mid_rst_state", int'(bus.capture_state), 0);
      chk("mid_rst_read_index", int'(bus.read_index), 0);
      chk("mid_rst_we", int'(bus.write_enable), 0);
      cyc(0, 0, 0, 0);
      chk("post_rst_we", int'(bus.write_enable), 0);

      // Random traffic with occasional vsync pulses and resets.
      vs = 0;
      for (int i = 0; i < 20000; i++) begin
         int sv;
         if ($urandom_range(0, 3) == 0)
            sv = $urandom_range(0, 200) - 100;
         else
            sv = $urandom_range(0, 65535) - 32768;
         if ($urandom_range(0, 149) == 0) vs = !vs;
         cyc($urandom_range(0, 2) != 0, sv, vs,
             $urandom_range(0, 2999) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
